ddr2_traffic_gen: RTL and testbench
===================================

// Module: ddr2_traffic_gen
// PURPOSE
//   Self-checking traffic source/sink in front of axi_wr_master and axi_rd_master.
//   After init_end and a start pulse, it writes NUM_BURSTS bursts of an incrementing pattern.
//   It then reads the same region back, compares every beat and reports pass/fail.
//   Used on board and in simulation to prove the ddr2_ctrl datapath end to end.
// PARAMETERS
//   ADDR_WIDTH  27   byte address width (ROW+COL+BA bits)
//   DATA_WIDTH  16   user data width (DQ_BITS*2)
//   BURST_LEN   8    beats per burst; driven on wr_len/rd_len (1..255)
//   NUM_BURSTS  16   bursts per pass (1..65535)
//   ADDR_STEP   16   address increment per burst
//   BASE_ADDR   0    address of the first burst
//   SEED        1    pattern value of the first beat
//   TIMEOUT     4096 max cycles in any wait state before abort
// PORTS
//   clk         in   1   user clock (same clock as the AXI masters)
//   rstn        in   1   asynchronous active-low reset
//   init_end    in   1   DDR2 initialisation complete
//   start       in   1   one-cycle pulse; accepted in IDLE or DONE only
//   busy        out  1   test in progress
//   done        out  1   test finished; held until the next accepted start
//   pass        out  1   valid while done: err_cnt==0, no timeout, no len_err
//   err_cnt     out  16  count of mismatched read beats, saturating
//   timeout     out  1   a wait state exceeded TIMEOUT cycles
//   len_err     out  1   a read burst delivered a beat count other than BURST_LEN
//   wr_trig     out  1   write burst request
//   wr_len      out  8   constant BURST_LEN
//   wr_addr     out  ADDR_WIDTH  burst start address
//   wr_data     out  DATA_WIDTH  current write beat
//   wr_data_en  in   1   master consumed wr_data this cycle
//   wr_ready    in   1   master accepts wr_trig
//   wr_done     in   1   write burst complete (B response seen)
//   rd_trig     out  1   read burst request
//   rd_len      out  8   constant BURST_LEN
//   rd_addr     out  ADDR_WIDTH  burst start address
//   rd_data     in   DATA_WIDTH  read beat
//   rd_data_en  in   1   rd_data valid
//   rd_ready    in   1   master accepts rd_trig
//   rd_done     in   1   read burst complete
// BEHAVIOUR
// - Reset values:
//   - all outputs 0, except wr_data=SEED, wr_addr=rd_addr=BASE_ADDR and wr_len=rd_len=BURST_LEN.
//   - An asserted rstn mid-test aborts immediately; the masters are reset by the same rstn.
// - FSM states: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE.
// - IDLE/DONE -> WR_REQ on start && init_end. start without init_end is ignored.
//   - On entry: clear err_cnt, timeout, len_err, done, pass and the burst counter.
//   - On entry: load wr_addr=rd_addr=BASE_ADDR, wr_data=SEED, rd_exp=SEED.
// - WR_REQ: wr_trig=1 (registered) and held until the cycle with wr_trig&&wr_ready.
//   - In that cycle wr_trig drops next edge and the FSM moves to WR_WAIT.
// - wr_data advances by 1 (mod 2^DATA_WIDTH) on the edge after each wr_data_en.
//   - The first beat of every burst is the value left by the previous burst, so the pattern is continuous.
// - WR_WAIT on wr_done:
//   - wr_addr += ADDR_STEP.
//   - Go to WR_REQ if bursts remain.
//   - Otherwise clear the burst counter and go to RD_REQ.
// - RD_REQ/RD_WAIT mirror the write states using rd_trig/rd_ready/rd_done and rd_addr.
// - On each rd_data_en:
//   - If rd_data != rd_exp, err_cnt += 1, saturating at 16'hFFFF.
//   - rd_exp increments mod 2^DATA_WIDTH.
//   - The per-burst beat counter increments.
// - On rd_done: if the beat counter != BURST_LEN, set len_err (sticky); clear the beat counter.
//   - rd_data_en and rd_done in the same cycle: count the beat first, then check.
// - After the last rd_done -> DONE: done=1, busy=0, pass computed that edge.
// - Watchdog:
//   - A counter runs in WR_REQ, WR_WAIT, RD_REQ and RD_WAIT and clears on every state change.
//   - On reaching TIMEOUT: set timeout=1, drop both trigs, go to DONE with pass=0.
// - busy=1 in all states except IDLE and DONE.
// - wr_data_en/rd_data_en outside their phase are ignored.
// - A start pulse while busy is ignored.
// TESTING
// - Default params, ddr2_ctrl + ddr2 model: start after init_end -> 16 write then 16 read bursts.
//   - Expect wr_addr 0,16..240 and beats 1..128 read back; done=1, pass=1, err_cnt=0.
// - Stub read master returns beat 5 of burst 2 as 16'hDEAD -> err_cnt=1, pass=0.
//   - rd_exp continues, so no further errors.
// - Stub holds wr_ready=0: wr_trig stays 1 for TIMEOUT cycles -> timeout=1, done=1, pass=0, wr_trig=0.
// - Stub gives 7 beats then rd_done in burst 0 -> len_err=1, pass=0.
// - SEED=16'hFFFE, NUM_BURSTS=1: written beats FFFE,FFFF,0000..0005 -> readback passes (wrap).
// - Start during WR_WAIT ignored; rstn low in RD_WAIT -> all outputs at reset values.
//   - A new start then re-runs the test and passes.

Source files
------------

// File: rtl/ddr2_traffic_gen_if.sv
// Burst request/data bundle between the traffic generator and the AXI write/read masters.
interface ddr2_traffic_gen_if #(
  parameter int unsigned ADDR_WIDTH = 27,
  parameter int unsigned DATA_WIDTH = 16
) ();
  logic                  wr_trig;
  logic [7:0]            wr_len;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_data_en;
  logic                  wr_ready;
  logic                  wr_done;
  logic                  rd_trig;
  logic [7:0]            rd_len;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_data_en;
  logic                  rd_ready;
  logic                  rd_done;

  modport master (
    output wr_trig, wr_len, wr_addr, wr_data,
    input  wr_data_en, wr_ready, wr_done,
    output rd_trig, rd_len, rd_addr,
    input  rd_data, rd_data_en, rd_ready, rd_done
  );

  modport slave (
    input  wr_trig, wr_len, wr_addr, wr_data,
    output wr_data_en, wr_ready, wr_done,
    input  rd_trig, rd_len, rd_addr,
    output rd_data, rd_data_en, rd_ready, rd_done
  );
endinterface

// File: rtl/ddr2_traffic_gen.sv
// Write-then-readback traffic generator: writes an incrementing pattern in bursts,
// reads the region back, counts mismatches and reports pass/fail.
module ddr2_traffic_gen #(
  parameter int unsigned            ADDR_WIDTH = 27,
  parameter int unsigned            DATA_WIDTH = 16,
  parameter int unsigned            BURST_LEN  = 8,
  parameter int unsigned            NUM_BURSTS = 16,
  parameter int unsigned            ADDR_STEP  = 16,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0,
  parameter logic [DATA_WIDTH-1:0]  SEED       = DATA_WIDTH'(1),
  parameter int unsigned            TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        init_end,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_cnt,
  output logic        timeout,
  output logic        len_err,
  ddr2_traffic_gen_if.master bus
);
  localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);
  localparam int unsigned BCNT_W = 16;
  localparam int unsigned BEAT_W = 9;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE} state_t;

  state_t                state, state_nxt;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d, rd_exp_q, rd_exp_d;
  logic [BCNT_W-1:0]     burst_q, burst_d;
  logic [BEAT_W-1:0]     beat_q, beat_d, beat_sum;
  logic [WDOG_W-1:0]     wdog_q, wdog_d;
  logic [15:0]           err_d;
  logic                  busy_d, done_d, pass_d, timeout_d, len_err_d;
  logic                  wr_trig_q, wr_trig_d, rd_trig_q, rd_trig_d;
  logic                  start_go, watch, wr_phase, rd_phase, wdog_hit, last_burst, rd_beat;

  assign start_go   = start && init_end && (state == IDLE || state == DONE);
  assign watch      = state inside {WR_REQ, WR_WAIT, RD_REQ, RD_WAIT};
  assign wr_phase   = state inside {WR_REQ, WR_WAIT};
  assign rd_phase   = state inside {RD_REQ, RD_WAIT};
  assign wdog_hit   = (wdog_q == WDOG_W'(TIMEOUT - 1));
  assign last_burst = (burst_q == BCNT_W'(NUM_BURSTS - 1));
  assign rd_beat    = rd_phase && bus.rd_data_en;
  // a beat arriving together with rd_done is counted before the length check
  assign beat_sum   = beat_q + BEAT_W'(rd_beat);

  assign bus.wr_trig = wr_trig_q;
  assign bus.wr_len  = 8'(BURST_LEN);
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.rd_trig = rd_trig_q;
  assign bus.rd_len  = 8'(BURST_LEN);
  assign bus.rd_addr = rd_addr_q;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state; a completed handshake wins over a watchdog expiry in the same cycle
  always_comb begin
    state_nxt = state;
    abort     = 1'b0;
    case (state)
      IDLE, DONE: if (start_go) state_nxt = WR_REQ;
      WR_REQ: begin
        if (wr_trig_q && bus.wr_ready) state_nxt = WR_WAIT;
        else if (wdog_hit)             begin state_nxt = DONE; abort = 1'b1; end
      end
      WR_WAIT: begin
        if (bus.wr_done)   state_nxt = last_burst ? RD_REQ : WR_REQ;
        else if (wdog_hit) begin state_nxt = DONE; abort = 1'b1; end
      end
      RD_REQ: begin
        if (rd_trig_q && bus.rd_ready) state_nxt = RD_WAIT;
        else if (wdog_hit)             begin state_nxt = DONE; abort = 1'b1; end
      end
      RD_WAIT: begin
        if (bus.rd_done)   state_nxt = last_burst ? DONE : RD_REQ;
        else if (wdog_hit) begin state_nxt = DONE; abort = 1'b1; end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of every registered output and datapath counter
  always_comb begin
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    wr_data_d = wr_data_q;
    rd_exp_d  = rd_exp_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    err_d     = err_cnt;
    timeout_d = timeout || abort;
    len_err_d = len_err;
    wdog_d    = (watch && state_nxt == state) ? wdog_q + WDOG_W'(1) : '0;

    if (start_go) begin
      wr_addr_d = BASE_ADDR;
      rd_addr_d = BASE_ADDR;
      wr_data_d = SEED;
      rd_exp_d  = SEED;
      burst_d   = '0;
      beat_d    = '0;
      err_d     = '0;
      timeout_d = 1'b0;
      len_err_d = 1'b0;
    end

    if (wr_phase && bus.wr_data_en) wr_data_d = wr_data_q + DATA_WIDTH'(1);

    if (state == WR_WAIT && bus.wr_done) begin
      wr_addr_d = wr_addr_q + ADDR_WIDTH'(ADDR_STEP);
      burst_d   = last_burst ? '0 : burst_q + BCNT_W'(1);
    end

    if (rd_beat) begin
      rd_exp_d = rd_exp_q + DATA_WIDTH'(1);
      beat_d   = beat_sum;
      if (bus.rd_data != rd_exp_q && err_cnt != 16'hFFFF) err_d = err_cnt + 16'd1;
    end

    if (state == RD_WAIT && bus.rd_done) begin
      if (beat_sum != BEAT_W'(BURST_LEN)) len_err_d = 1'b1;
      beat_d    = '0;
      rd_addr_d = rd_addr_q + ADDR_WIDTH'(ADDR_STEP);
      burst_d   = last_burst ? '0 : burst_q + BCNT_W'(1);
    end

    busy_d    = state_nxt inside {WR_REQ, WR_WAIT, RD_REQ, RD_WAIT};
    done_d    = (state_nxt == DONE);
    wr_trig_d = (state_nxt == WR_REQ);
    rd_trig_d = (state_nxt == RD_REQ);
    pass_d    = (state_nxt == DONE) && (err_d == 16'd0) && !timeout_d && !len_err_d;
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_addr_q <= BASE_ADDR;
      rd_addr_q <= BASE_ADDR;
      wr_data_q <= SEED;
      rd_exp_q  <= SEED;
      burst_q   <= '0;
      beat_q    <= '0;
      wdog_q    <= '0;
      err_cnt   <= '0;
      timeout   <= 1'b0;
      len_err   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      wr_trig_q <= 1'b0;
      rd_trig_q <= 1'b0;
    end else begin
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      wr_data_q <= wr_data_d;
      rd_exp_q  <= rd_exp_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      wdog_q    <= wdog_d;
      err_cnt   <= err_d;
      timeout   <= timeout_d;
      len_err   <= len_err_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      wr_trig_q <= wr_trig_d;
      rd_trig_q <= rd_trig_d;
    end
  end
endmodule

// File: tb/tb_ddr2_traffic_gen.sv
// Bench for ddr2_traffic_gen: randomized stub masters with a memory, a queue-based
// reference of expected addresses/beats/status, and a decoupled monitor.
`timescale 1ns/1ps
module tb_ddr2_traffic_gen;
  localparam int unsigned   AW   = 27;
  localparam int unsigned   DW   = 16;
  localparam int unsigned   BL   = 8;
  localparam int unsigned   NB   = 4;
  localparam int unsigned   STEP = 16;
  localparam int unsigned   TO   = 200;
  localparam logic [AW-1:0] BASE = 27'h100;
  localparam logic [DW-1:0] SEED = 16'hFFF4;

  typedef struct packed {logic [15:0] err; logic to; logic le; logic ps;} st_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        init_end = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass, timeout, len_err;
  logic [15:0] err_cnt;

  ddr2_traffic_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ddr2_traffic_gen #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .NUM_BURSTS(NB),
    .ADDR_STEP(STEP), .BASE_ADDR(BASE), .SEED(SEED), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rstn(rstn), .init_end(init_end), .start(start),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .timeout(timeout), .len_err(len_err), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [AW-1:0] exp_wa[$];
  logic [AW-1:0] exp_ra[$];
  logic [DW-1:0] exp_wd[$];
  st_t           exp_st[$];
  logic [DW-1:0] mem [longint];
  bit wr_stall = 0, short_en = 0, corrupt_en = 0;
  int corrupt_b = 0, corrupt_i = 0, rd_burst_idx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got no event want event", name);
  endtask

  function automatic longint key(input logic [AW-1:0] a, input int b);
    return longint'(a) * 256 + longint'(b);
  endfunction

  // Reference: addresses, write pattern and final status derived from the test rules
  task automatic push_expect(input bit stall);
    int k, errs, n;
    logic [DW-1:0] v, want;
    if (stall) begin
      exp_st.push_back('{err: 16'd0, to: 1'b1, le: 1'b0, ps: 1'b0});
      return;
    end
    for (int b = 0; b < NB; b++) begin
      exp_wa.push_back(BASE + AW'(b * STEP));
      exp_ra.push_back(BASE + AW'(b * STEP));
    end
    for (int j = 0; j < NB * BL; j++) exp_wd.push_back(SEED + DW'(j));
    k = 0;
    errs = 0;
    for (int b = 0; b < NB; b++) begin
      n = (short_en && b == 0) ? BL - 1 : BL;
      for (int i = 0; i < n; i++) begin
        v    = (corrupt_en && b == corrupt_b && i == corrupt_i) ? 16'hDEAD : SEED + DW'(b * BL + i);
        want = SEED + DW'(k);
        if (v != want) errs++;
        k++;
      end
    end
    exp_st.push_back('{err: 16'(errs), to: 1'b0, le: short_en, ps: (errs == 0) && !short_en});
  endtask

  task automatic flush();
    exp_wa.delete();
    exp_ra.delete();
    exp_wd.delete();
    exp_st.delete();
  endtask

  // Write-side stub master
  initial begin : wr_slave
    logic [AW-1:0] a;
    bus.wr_ready = 1'b0; bus.wr_data_en = 1'b0; bus.wr_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.wr_ready = !wr_stall && ($urandom_range(0, 1) == 1);
      if (bus.wr_trig && bus.wr_ready) begin
        a = bus.wr_addr;
        @(posedge clk); #1;
        bus.wr_ready = 1'b0;
        for (int b = 0; b < BL; b++) begin
          if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
          mem[key(a, b)] = bus.wr_data;
          bus.wr_data_en = 1'b1;
          @(posedge clk); #1;
          bus.wr_data_en = 1'b0;
        end
        bus.wr_done = 1'b1;
        @(posedge clk); #1;
        bus.wr_done = 1'b0;
      end
    end
  end

  // Read-side stub master with fault injection knobs
  initial begin : rd_slave
    logic [AW-1:0] a;
    int bi, n;
    bit together;
    bus.rd_ready = 1'b0; bus.rd_data_en = 1'b0; bus.rd_done = 1'b0; bus.rd_data = '0;
    forever begin
      @(posedge clk); #1;
      bus.rd_ready = ($urandom_range(0, 1) == 1);
      if (bus.rd_trig && bus.rd_ready) begin
        a  = bus.rd_addr;
        bi = rd_burst_idx;
        rd_burst_idx++;
        n  = (short_en && bi == 0) ? BL - 1 : BL;
        together = ($urandom_range(0, 1) == 1);
        @(posedge clk); #1;
        bus.rd_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
          if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
          if (corrupt_en && bi == corrupt_b && i == corrupt_i) bus.rd_data = 16'hDEAD;
          else bus.rd_data = mem.exists(key(a, i)) ? mem[key(a, i)] : '0;
          bus.rd_data_en = 1'b1;
          if (together && i == n - 1) bus.rd_done = 1'b1;
          @(posedge clk); #1;
          bus.rd_data_en = 1'b0;
          bus.rd_done = 1'b0;
        end
        if (!together) begin
          bus.rd_done = 1'b1;
          @(posedge clk); #1;
          bus.rd_done = 1'b0;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a handshake, beat or completion
  initial begin : monitor
    logic done_q;
    int trig_run, last_run;
    st_t s;
    done_q = 1'b0; trig_run = 0; last_run = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        done_q = 1'b0; trig_run = 0;
      end else begin
        if (bus.wr_trig) trig_run++;
        else if (trig_run != 0) begin last_run = trig_run; trig_run = 0; end
        if (bus.wr_trig && bus.wr_ready) begin
          if (exp_wa.size() == 0) fail_now("wr_addr_unexpected");
          else chk("wr_addr", 32'(bus.wr_addr), 32'(exp_wa.pop_front()));
        end
        if (bus.wr_data_en) begin
          if (exp_wd.size() == 0) fail_now("wr_data_unexpected");
          else chk("wr_data", 32'(bus.wr_data), 32'(exp_wd.pop_front()));
        end
        if (bus.rd_trig && bus.rd_ready) begin
          if (exp_ra.size() == 0) fail_now("rd_addr_unexpected");
          else chk("rd_addr", 32'(bus.rd_addr), 32'(exp_ra.pop_front()));
        end
        if (done && !done_q) begin
          if (exp_st.size() == 0) fail_now("done_unexpected");
          else begin
            s = exp_st.pop_front();
            chk("err_cnt", 32'(err_cnt), 32'(s.err));
            chk("timeout", 32'(timeout), 32'(s.to));
            chk("len_err", 32'(len_err), 32'(s.le));
            chk("pass", 32'(pass), 32'(s.ps));
            chk("busy_at_done", 32'(busy), 32'd0);
            chk("wr_trig_at_done", 32'(bus.wr_trig), 32'd0);
            chk("rd_trig_at_done", 32'(bus.rd_trig), 32'd0);
            if (s.to) chk("wr_trig_cycles", 32'(last_run), 32'(TO));
          end
        end
        done_q = done;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_len_err"}, 32'(len_err), 32'd0);
    chk({tag, "_wr_trig"}, 32'(bus.wr_trig), 32'd0);
    chk({tag, "_rd_trig"}, 32'(bus.rd_trig), 32'd0);
    chk({tag, "_wr_data"}, 32'(bus.wr_data), 32'(SEED));
    chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'(BASE));
    chk({tag, "_rd_addr"}, 32'(bus.rd_addr), 32'(BASE));
    chk({tag, "_wr_len"}, 32'(bus.wr_len), 32'(BL));
    chk({tag, "_rd_len"}, 32'(bus.rd_len), 32'(BL));
  endtask

  task automatic run_case(input bit stall, input bit shrt, input bit corr, input bit mid_start);
    bit ok;
    wr_stall = stall; short_en = shrt; corrupt_en = corr;
    corrupt_b = int'($urandom_range(0, NB - 1));
    corrupt_i = int'($urandom_range(0, BL - 1));
    rd_burst_idx = 0;
    flush();
    push_expect(stall);
    pulse_start();
    if (mid_start) begin
      ok = 0;
      for (int c = 0; c < 500 && !ok; c++) begin
        @(negedge clk);
        if (bus.wr_trig && bus.wr_ready) ok = 1;
      end
      if (!ok) fail_now("wr_handshake_wait");
      else begin
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
    end
    ok = 0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(negedge clk);
      if (done) ok = 1;
    end
    if (!ok) fail_now("done_wait");
    repeat (2) @(negedge clk);
    chk("wr_addr_left", 32'(exp_wa.size()), 32'd0);
    chk("wr_data_left", 32'(exp_wd.size()), 32'd0);
    chk("rd_addr_left", 32'(exp_ra.size()), 32'd0);
    chk("status_left", 32'(exp_st.size()), 32'd0);
    wr_stall = 0; short_en = 0; corrupt_en = 0;
  endtask

  initial begin : main
    bit ok;
    repeat (3) @(posedge clk);
    #1 check_reset("rst");
    @(posedge clk); #1 rstn = 1'b1;

    pulse_start();
    repeat (5) @(posedge clk);
    #1;
    chk("busy_no_init", 32'(busy), 32'd0);
    chk("wr_trig_no_init", 32'(bus.wr_trig), 32'd0);
    init_end = 1'b1;

    run_case(1'b0, 1'b0, 1'b0, 1'b0);
    run_case(1'b0, 1'b0, 1'b0, 1'b1);
    run_case(1'b0, 1'b0, 1'b1, 1'b0);
    run_case(1'b0, 1'b1, 1'b0, 1'b0);
    run_case(1'b1, 1'b0, 1'b0, 1'b0);

    // Abort with reset in the middle of a read burst, then rerun
    rd_burst_idx = 0;
    flush();
    push_expect(1'b0);
    pulse_start();
    ok = 0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clk);
      if (bus.rd_trig && bus.rd_ready) ok = 1;
    end
    if (!ok) fail_now("rd_handshake_wait");
    repeat (3) @(posedge clk);
    #3 rstn = 1'b0;
    #1 check_reset("mid_rst");
    flush();
    @(posedge clk); #1 rstn = 1'b1;
    repeat (30) @(posedge clk);
    run_case(1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
